// File: rtl/barrett_red_stream_ctrl_pkg.sv
// Shared widths and latency default for the Barrett reduction stream wrapper.
package barrett_red_stream_ctrl_pkg;
  localparam int RED_LAT_DEF = 9;
  localparam int OP_W        = 63;
  localparam int RES_W       = 30;
endpackage

// File: rtl/barrett_red_stream_ctrl_if.sv
// Operand stream, reducer port and result stream bundled for the wrapper.
interface barrett_red_stream_ctrl_if #(parameter int IDX_W = 16);
  import barrett_red_stream_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_data;
  logic [OP_W-1:0]  red_a;
  logic             red_sel_60_63;
  logic             red_only_multiply;
  logic [RES_W-1:0] red_b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, red_b, out_ready,
    output in_ready, red_a, red_sel_60_63, red_only_multiply, out_valid, out_data, out_idx
  );

  modport master (
    output in_valid, in_data, red_b, out_ready,
    input  in_ready, red_a, red_sel_60_63, red_only_multiply, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/barrett_res_fifo.sv
// First-word-fall-through result FIFO; pointers carry one extra wrap bit.
module barrett_res_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 46
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_do_pop;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop = i_pop && !w_empty;
  assign o_valid  = !w_empty;
  assign o_data   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/barrett_red_stream_ctrl.sv
// Batch issue into the Barrett reducer, latency tracking, and credit-protected result FIFO.
module barrett_red_stream_ctrl
  import barrett_red_stream_ctrl_pkg::*;
#(
  parameter int RED_LAT    = RED_LAT_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int IDX_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [IDX_W-1:0]     i_len,
  input  logic                 i_sel_60_63_cfg,
  output logic                 o_busy,
  output logic                 o_done,
  barrett_red_stream_ctrl_if.slave s_if
);
  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | issuing operands while credits allow
  // S_DRAIN | all issued, waiting for pipeline and FIFO to empty
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = IDX_W + RES_W;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_len, r_issued;
  logic             r_sel;
  logic [CW-1:0]    r_credits;
  logic [OP_W-1:0]  r_red_a;
  logic [RED_LAT-1:0] r_dl_v;
  logic [IDX_W-1:0] r_dl_idx [RED_LAT];
  logic             w_in_ready, w_issue, w_pop, w_full, w_fifo_valid;
  logic [FW-1:0]    w_fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    w_in_ready  = (r_state == S_RUN) && (r_credits != '0) && (r_issued < r_len);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (r_issued == r_len) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_credits == CW'(FIFO_DEPTH)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_issue = s_if.in_valid && w_in_ready;
  assign w_pop   = w_fifo_valid && s_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_sel     <= 1'b0;
      r_issued  <= '0;
      r_credits <= CW'(FIFO_DEPTH);
      r_red_a   <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_len    <= i_len;
        r_sel    <= i_sel_60_63_cfg;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + IDX_W'(1);
      end
      if (w_issue) r_red_a <= s_if.in_data;
      if (w_issue && !w_pop)      r_credits <= r_credits - CW'(1);
      else if (!w_issue && w_pop) r_credits <= r_credits + CW'(1);
    end
  end

  // Head stage runs alongside r_red_a; the last stage lines up with red_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_v <= '0;
      for (int i = 0; i < RED_LAT; i++) r_dl_idx[i] <= '0;
    end else begin
      r_dl_v      <= {r_dl_v[RED_LAT-2:0], w_issue};
      r_dl_idx[0] <= r_issued;
      for (int i = 1; i < RED_LAT; i++) r_dl_idx[i] <= r_dl_idx[i-1];
    end
  end

  barrett_res_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_dl_v[RED_LAT-1] && !w_full),
    .i_data  ({r_dl_idx[RED_LAT-1], s_if.red_b}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_full  (w_full)
  );

  assign s_if.in_ready          = w_in_ready;
  assign s_if.red_a             = r_red_a;
  assign s_if.red_sel_60_63     = r_sel;
  assign s_if.red_only_multiply = 1'b0;
  assign s_if.out_valid         = w_fifo_valid;
  assign s_if.out_data          = w_fifo_dout[RES_W-1:0];
  assign s_if.out_idx           = w_fifo_dout[FW-1:RES_W];
endmodule

// File: tb/tb_barrett_red_stream_ctrl.sv
// Scoreboard bench: behavioural reducer (a mod p), randomized issue/backpressure, queue-based checking.
module tb_barrett_red_stream_ctrl;
  import barrett_red_stream_ctrl_pkg::*;

  localparam int RED_LAT    = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int IDX_W      = 16;
  localparam longint unsigned P0 = 64'd1073479681;
  localparam longint unsigned P1 = 64'd1073741789;

  typedef struct {
    longint unsigned data;
    int              idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [IDX_W-1:0] len = '0;
  logic sel = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  barrett_red_stream_ctrl_if #(.IDX_W(IDX_W)) bus ();

  barrett_red_stream_ctrl #(.RED_LAT(RED_LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (start),
    .i_len           (len),
    .i_sel_60_63_cfg (sel),
    .o_busy          (busy),
    .o_done          (done),
    .s_if            (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];
  longint unsigned none_q[$];
  int ready_mode = 0;
  int valid_pct = 100;
  int issued_cnt = 0;
  bit abort_drv = 0;
  int max_out = 0;
  int done_cnt = 0, busy_cnt = 0, rdy_cnt = 0;

  function automatic longint unsigned modp(input bit s);
    return s ? P1 : P0;
  endfunction

  function automatic void check(input string name, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic void fail(input string name, input longint unsigned act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed %0d", name, act);
  endfunction

  // Reducer stand-in: RED_LAT-1 cycles after red_a is registered, red_b = a mod p.
  logic [63:0] red_pipe [RED_LAT-1];
  always @(posedge clk) begin
    red_pipe[0] <= {bus.red_sel_60_63, bus.red_a};
    for (int i = 1; i < RED_LAT-1; i++) red_pipe[i] <= red_pipe[i-1];
  end

  function automatic logic [29:0] reduce(input logic [63:0] x);
    longint unsigned a;
    a = {1'b0, x[62:0]};
    return 30'(a % modp(x[63]));
  endfunction

  assign bus.red_b = reduce(red_pipe[RED_LAT-2]);

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (bus.in_ready) rdy_cnt++;
  end

  // Output monitor: pops the scoreboard whenever a pop will happen at the next edge.
  initial begin
    exp_t e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_out idx", longint'(bus.out_idx));
        else begin
          e = exp_q.pop_front();
          check("out_data", longint'(bus.out_data), e.data);
          check("out_idx", longint'(bus.out_idx), longint'(e.idx));
        end
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > max_out) max_out = exp_q.size();
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  task automatic run_batch(input int n, input bit s, input longint unsigned dq[$]);
    int cyc = 0;
    int k = 0;
    bit fire;
    longint unsigned d;
    @(posedge clk); #1;
    start = 1'b1; len = IDX_W'(n); sel = s; issued_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    while (issued_cnt < n && !abort_drv) begin
      if (!bus.in_valid && $urandom_range(0, 99) < valid_pct) begin
        if (k < dq.size()) d = dq[k];
        else begin
          d = {$urandom, $urandom};
          d[63] = 1'b0;
        end
        k++;
        bus.in_valid = 1'b1;
        bus.in_data  = d[62:0];
      end
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (fire) begin
        exp_q.push_back('{data: longint'(bus.in_data) % modp(s), idx: issued_cnt});
        issued_cnt++;
      end
      @(posedge clk); #1;
      if (fire) bus.in_valid = 1'b0;
      if (++cyc > 20000) begin
        fail("issue_timeout issued", longint'(issued_cnt));
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    int d0 = done_cnt;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (++cyc > 20000) begin
        fail({name, "_done_timeout"}, longint'(cyc));
        return;
      end
    end
    check({name, "_drained"}, longint'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, longint'(done_cnt - d0), 1);
  endtask

  initial begin
    longint unsigned t1[$];
    int b0, d0, r0, w;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_red_a", bus.red_a, 0);
    check("rst_red_sel", bus.red_sel_60_63, 0);
    #11 rst_n = 1'b1;

    // Directed batch from the test plan
    ready_mode = 0; valid_pct = 100;
    t1 = '{64'd5 * 64'd1073741824 + 64'd7, 64'h0FFF_FFFF_FFFF_FFFF, 64'd0, P0 * 64'd3 + 64'd2};
    run_batch(4, 0, t1);
    wait_done("t1");
    check("only_multiply", bus.red_only_multiply, 0);

    // Full backpressure: issue must stall at FIFO_DEPTH
    ready_mode = 1;
    fork
      run_batch(40, 0, none_q);
      begin
        w = 0;
        while (issued_cnt < FIFO_DEPTH && w < 300) begin @(negedge clk); w++; end
        repeat (20) @(negedge clk);
        check("bp_issued", longint'(issued_cnt), FIFO_DEPTH);
        check("bp_in_ready", bus.in_ready, 0);
        ready_mode = 0;
      end
    join
    wait_done("t2");

    // Empty batch
    b0 = busy_cnt; d0 = done_cnt; r0 = rdy_cnt;
    @(posedge clk); #1; start = 1'b1; len = '0; sel = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("len0_done_cnt", longint'(done_cnt - d0), 1);
    check("len0_busy_cnt", longint'(busy_cnt - b0), 1);
    check("len0_no_issue", longint'(rdy_cnt - r0), 0);

    // Long random batch with gaps on both sides, then a sel=1 batch
    ready_mode = 2; valid_pct = 60;
    run_batch(1000, 0, none_q);
    wait_done("t4");
    run_batch(50, 1, none_q);
    wait_done("t4s");

    // Reset in the middle of a batch with elements in flight
    ready_mode = 1; valid_pct = 100; abort_drv = 0;
    fork
      run_batch(10, 1, none_q);
      begin
        w = 0;
        while (issued_cnt < 5 && w < 100) begin @(negedge clk); w++; end
        @(posedge clk); #2;
        abort_drv = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_red_a", bus.red_a, 0);
        check("mid_rst_red_sel", bus.red_sel_60_63, 0);
      end
    join
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk); rst_n = 1'b1;
    abort_drv = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_rst_no_done", longint'(done_cnt - d0), 0);
    ready_mode = 0;
    run_batch(3, 0, none_q);
    wait_done("t5");

    // start while busy is ignored
    ready_mode = 2; valid_pct = 70;
    fork
      run_batch(8, 0, none_q);
      begin
        repeat (4) @(posedge clk);
        #1; start = 1'b1; len = IDX_W'(3); sel = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
    join
    wait_done("t6");
    check("t6_sel_kept", bus.red_sel_60_63, 0);

    check("max_outstanding_le_depth", longint'(max_out <= FIFO_DEPTH), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
